// File: rtl/fading_mark_board.sv
// rtl/fading_mark_board.sv - board store for disappearing-mark tic-tac-toe
// FADE_PREVIEW_EN adds next_evict_x/next_evict_o (oldest live cell once a player is full).
module fading_mark_board #(
  parameter int CELLS   = 9,
  parameter int KEEP    = 3,
  parameter int FIRST_X = 1,
  parameter int PW      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      mark_valid,
  input  logic                      mark_player,
  input  logic [PW-1:0]             mark_pos,
  output logic [2*CELLS-1:0]        grid,
  output logic                      whos_turn,
  output logic                      mark_accept,
  output logic                      mark_reject,
  output logic                      evict_valid,
  output logic [PW-1:0]             evict_pos,
  output logic [$clog2(KEEP+1)-1:0] x_count,
  output logic [$clog2(KEEP+1)-1:0] o_count
`ifdef FADE_PREVIEW_EN
  ,
  output logic [PW-1:0]             next_evict_x,
  output logic [PW-1:0]             next_evict_o
`endif
);

  localparam int CW   = $clog2(KEEP + 1);
  localparam int PTRW = (KEEP > 1) ? $clog2(KEEP) : 1;
  localparam logic [CW-1:0]   KEEP_C   = CW'(KEEP);
  localparam logic [PTRW-1:0] LAST_PTR = PTRW'(KEEP - 1);
  localparam logic [PW:0]     CELLS_C  = (PW + 1)'(CELLS);
  localparam logic [1:0]      CODE_X   = 2'b10;
  localparam logic [1:0]      CODE_O   = 2'b01;
  localparam logic [1:0]      EMPTY    = 2'b00;

  // Index 1 holds X's history, index 0 holds O's, matching mark_player.
  logic [PW-1:0]   fifo   [2][KEEP];
  logic [PTRW-1:0] head   [2];
  logic [PTRW-1:0] tail   [2];
  logic [CW-1:0]   count  [2];

  logic [PW-1:0]        fifo_n  [2][KEEP];
  logic [PTRW-1:0]      head_n  [2];
  logic [PTRW-1:0]      tail_n  [2];
  logic [CW-1:0]        count_n [2];
  logic [2*CELLS-1:0]   grid_n;
  logic                 turn_n;
  logic                 accept_n;
  logic                 reject_n;
  logic                 evict_n;
  logic [PW-1:0]        evict_pos_n;
  logic                 p;
  logic [1:0]           target_cell;
  logic [PW-1:0]        oldest_pos;
  logic                 in_range;

  function automatic logic [PTRW-1:0] bump(input logic [PTRW-1:0] v);
    return (v == LAST_PTR) ? '0 : v + PTRW'(1);
  endfunction

  assign x_count = count[1];
  assign o_count = count[0];

  always_comb begin
    fifo_n      = fifo;
    head_n      = head;
    tail_n      = tail;
    count_n     = count;
    grid_n      = grid;
    turn_n      = whos_turn;
    accept_n    = 1'b0;
    reject_n    = 1'b0;
    evict_n     = 1'b0;
    evict_pos_n = '0;
    p           = mark_player;
    oldest_pos  = fifo[p][head[p]];
    in_range    = ({1'b0, mark_pos} < CELLS_C);
    target_cell = EMPTY;
    for (int i = 0; i < CELLS; i++) begin
      if (mark_pos == PW'(i)) target_cell = grid[2*i +: 2];
    end

    if (mark_valid) begin
      if (!in_range || target_cell != EMPTY || mark_player != whos_turn) begin
        reject_n = 1'b1;
      end else begin
        accept_n = 1'b1;
        turn_n   = ~whos_turn;
        // A full history fades its oldest mark; the new mark reuses that slot.
        if (count[p] == KEEP_C) begin
          for (int i = 0; i < CELLS; i++) begin
            if (oldest_pos == PW'(i)) grid_n[2*i +: 2] = EMPTY;
          end
          evict_n     = 1'b1;
          evict_pos_n = oldest_pos;
          head_n[p]   = bump(head[p]);
        end else begin
          count_n[p] = count[p] + CW'(1);
        end
        fifo_n[p][tail[p]] = mark_pos;
        tail_n[p]          = bump(tail[p]);
        for (int i = 0; i < CELLS; i++) begin
          if (mark_pos == PW'(i)) grid_n[2*i +: 2] = p ? CODE_X : CODE_O;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      grid        <= '0;
      whos_turn   <= (FIRST_X != 0);
      mark_accept <= 1'b0;
      mark_reject <= 1'b0;
      evict_valid <= 1'b0;
      evict_pos   <= '0;
      for (int q = 0; q < 2; q++) begin
        head[q]  <= '0;
        tail[q]  <= '0;
        count[q] <= '0;
        for (int k = 0; k < KEEP; k++) fifo[q][k] <= '0;
      end
`ifdef FADE_PREVIEW_EN
      next_evict_x <= '0;
      next_evict_o <= '0;
`endif
    end else begin
      grid        <= grid_n;
      whos_turn   <= turn_n;
      mark_accept <= accept_n;
      mark_reject <= reject_n;
      evict_valid <= evict_n;
      evict_pos   <= evict_pos_n;
      for (int q = 0; q < 2; q++) begin
        head[q]  <= head_n[q];
        tail[q]  <= tail_n[q];
        count[q] <= count_n[q];
        for (int k = 0; k < KEEP; k++) fifo[q][k] <= fifo_n[q][k];
      end
`ifdef FADE_PREVIEW_EN
      next_evict_x <= (count_n[1] == KEEP_C) ? fifo_n[1][head_n[1]] : '0;
      next_evict_o <= (count_n[0] == KEEP_C) ? fifo_n[0][head_n[0]] : '0;
`endif
    end
  end

endmodule

// File: tb/tb_fading_mark_board.sv
// tb/tb_fading_mark_board.sv - scoreboard bench for fading_mark_board
// Covers FADE_PREVIEW_EN ports when that macro is defined.
module tb_fading_mark_board;

  typedef struct {
    logic        acc;
    logic        ev;
    logic [3:0]  evp;
    logic [31:0] grid;
    logic [2:0]  xc;
    logic [2:0]  oc;
    logic        turn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;

  logic        a_valid = 1'b0, a_player = 1'b0;
  logic [3:0]  a_pos = '0;
  logic [17:0] a_grid;
  logic        a_turn, a_acc, a_rej, a_ev;
  logic [3:0]  a_evp;
  logic [1:0]  a_xc, a_oc;
  logic [3:0]  a_nex, a_neo;

  logic        b_valid = 1'b0, b_player = 1'b0;
  logic [3:0]  b_pos = '0;
  logic [31:0] b_grid;
  logic        b_turn, b_acc, b_rej, b_ev;
  logic [3:0]  b_evp;
  logic [2:0]  b_xc, b_oc;
  logic [3:0]  b_nex, b_neo;

  int total = 0;
  int bad = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t last_e[2];
  exp_t ea, eb;

  always #5 clk = ~clk;

  fading_mark_board dut_a (
    .clk(clk), .rst(rst), .clear(clear),
    .mark_valid(a_valid), .mark_player(a_player), .mark_pos(a_pos),
    .grid(a_grid), .whos_turn(a_turn), .mark_accept(a_acc), .mark_reject(a_rej),
    .evict_valid(a_ev), .evict_pos(a_evp), .x_count(a_xc), .o_count(a_oc)
`ifdef FADE_PREVIEW_EN
    , .next_evict_x(a_nex), .next_evict_o(a_neo)
`endif
  );

  fading_mark_board #(.CELLS(16), .KEEP(4), .FIRST_X(0), .PW(4)) dut_b (
    .clk(clk), .rst(rst), .clear(clear),
    .mark_valid(b_valid), .mark_player(b_player), .mark_pos(b_pos),
    .grid(b_grid), .whos_turn(b_turn), .mark_accept(b_acc), .mark_reject(b_rej),
    .evict_valid(b_ev), .evict_pos(b_evp), .x_count(b_xc), .o_count(b_oc)
`ifdef FADE_PREVIEW_EN
    , .next_evict_x(b_nex), .next_evict_o(b_neo)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Cell 0 is the leftmost character: X, O or '.' for empty.
  function automatic logic [31:0] g(input string s);
    logic [31:0] r = '0;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "X") r[2*i +: 2] = 2'b10;
      else if (s[i] == "O") r[2*i +: 2] = 2'b01;
    end
    return r;
  endfunction

  task automatic drive(input int sel, input logic pl, input int pos, input exp_t e);
    if (sel == 0) begin
      a_valid = 1'b1; a_player = pl; a_pos = 4'(pos); qa.push_back(e);
    end else begin
      b_valid = 1'b1; b_player = pl; b_pos = 4'(pos); qb.push_back(e);
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic mv(input int sel, input logic pl, input int pos, input string gs,
                    input int xc, input int oc, input logic turn, input int evp);
    exp_t e;
    e.acc = 1'b1; e.ev = (evp >= 0); e.evp = (evp >= 0) ? 4'(evp) : 4'd0;
    e.grid = g(gs); e.xc = 3'(xc); e.oc = 3'(oc); e.turn = turn;
    last_e[sel] = e;
    drive(sel, pl, pos, e);
  endtask

  task automatic rj(input int sel, input logic pl, input int pos);
    exp_t e = last_e[sel];
    e.acc = 1'b0; e.ev = 1'b0; e.evp = 4'd0;
    drive(sel, pl, pos, e);
  endtask

  always @(negedge clk) begin
    if (a_acc || a_rej) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_pulse: got acc=%0b rej=%0b expected none", a_acc, a_rej);
      end else begin
        ea = qa.pop_front();
        chk("a_accept", a_acc, ea.acc);
        chk("a_reject", a_rej, !ea.acc);
        chk("a_evict_valid", a_ev, ea.ev);
        chk("a_evict_pos", a_evp, ea.evp);
        chk("a_grid", a_grid, ea.grid);
        chk("a_x_count", a_xc, ea.xc);
        chk("a_o_count", a_oc, ea.oc);
        chk("a_whos_turn", a_turn, ea.turn);
      end
    end
  end

  always @(negedge clk) begin
    if (b_acc || b_rej) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_pulse: got acc=%0b rej=%0b expected none", b_acc, b_rej);
      end else begin
        eb = qb.pop_front();
        chk("b_accept", b_acc, eb.acc);
        chk("b_reject", b_rej, !eb.acc);
        chk("b_evict_valid", b_ev, eb.ev);
        chk("b_evict_pos", b_evp, eb.evp);
        chk("b_grid", b_grid, eb.grid);
        chk("b_x_count", b_xc, eb.xc);
        chk("b_o_count", b_oc, eb.oc);
        chk("b_whos_turn", b_turn, eb.turn);
      end
    end
  end

  task automatic chk_idle_a(input string tag);
    chk({tag, "_grid"}, a_grid, 0);
    chk({tag, "_counts"}, {a_xc, a_oc}, 0);
    chk({tag, "_turn"}, a_turn, 1);
    chk({tag, "_pulses"}, {a_acc, a_rej, a_ev}, 0);
    chk({tag, "_evict_pos"}, a_evp, 0);
  endtask

  initial begin
    last_e[0] = '{acc: 1'b0, ev: 1'b0, evp: 4'd0, grid: 32'd0, xc: 3'd0, oc: 3'd0, turn: 1'b1};
    last_e[1] = '{acc: 1'b0, ev: 1'b0, evp: 4'd0, grid: 32'd0, xc: 3'd0, oc: 3'd0, turn: 1'b0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_idle_a("reset_a");
    chk("reset_b_turn", b_turn, 0);
    chk("reset_b_grid", b_grid, 0);

    mv(0, 1, 0, "X........", 1, 0, 0, -1);
    mv(0, 0, 4, "X...O....", 1, 1, 1, -1);
    mv(0, 1, 1, "XX..O....", 2, 1, 0, -1);
    mv(0, 0, 5, "XX..OO...", 2, 2, 1, -1);
    mv(0, 1, 2, "XXX.OO...", 3, 2, 0, -1);
    mv(0, 0, 6, "XXX.OOO..", 3, 3, 1, -1);
    mv(0, 1, 3, ".XXXOOO..", 3, 3, 0, 0);
    rj(0, 0, 1);
    rj(0, 0, 9);
    rj(0, 1, 7);
    rj(0, 0, 4);
    mv(0, 0, 7, ".XXX.OOO.", 3, 3, 1, 4);
    mv(0, 1, 4, "..XXXOOO.", 3, 3, 0, 1);
    mv(0, 0, 0, "O.XXX.OO.", 3, 3, 1, 5);
    mv(0, 1, 1, "OX.XX.OO.", 3, 3, 0, 2);
    mv(0, 0, 8, "OX.XX..OO", 3, 3, 1, 6);
    mv(0, 1, 2, "OXX.X..OO", 3, 3, 0, 3);
    mv(0, 0, 3, "OXXOX...O", 3, 3, 1, 7);

    clear = 1'b1; a_valid = 1'b1; a_player = 1'b1; a_pos = 4'd5;
    @(negedge clk);
    clear = 1'b0; a_valid = 1'b0;
    chk_idle_a("clear");

    mv(0, 1, 0, "X........", 1, 0, 0, -1);
    mv(0, 0, 1, "XO.......", 1, 1, 1, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_a("midreset");
    last_e[0] = '{acc: 1'b0, ev: 1'b0, evp: 4'd0, grid: 32'd0, xc: 3'd0, oc: 3'd0, turn: 1'b1};
    last_e[1] = '{acc: 1'b0, ev: 1'b0, evp: 4'd0, grid: 32'd0, xc: 3'd0, oc: 3'd0, turn: 1'b0};
    rj(0, 0, 4);
    mv(0, 1, 4, "....X....", 1, 0, 0, -1);

    mv(1, 0, 15, "...............O", 0, 1, 1, -1);
    mv(1, 1, 0,  "X..............O", 1, 1, 0, -1);
    mv(1, 0, 14, "X.............OO", 1, 2, 1, -1);
    mv(1, 1, 1,  "XX............OO", 2, 2, 0, -1);
    mv(1, 0, 13, "XX...........OOO", 2, 3, 1, -1);
    mv(1, 1, 2,  "XXX..........OOO", 3, 3, 0, -1);
    mv(1, 0, 12, "XXX.........OOOO", 3, 4, 1, -1);
`ifdef FADE_PREVIEW_EN
    chk("b_next_evict_o_full", b_neo, 15);
    chk("b_next_evict_x_notfull", b_nex, 0);
`endif
    mv(1, 1, 3,  "XXXX........OOOO", 4, 4, 0, -1);
    mv(1, 0, 11, "XXXX.......OOOO.", 4, 4, 1, 15);
`ifdef FADE_PREVIEW_EN
    chk("b_next_evict_o_after", b_neo, 14);
`endif

    repeat (3) @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
